// File: rtl/restoring_divider_nbit.sv
// restoring_divider_nbit
// Iterative unsigned restoring divider: N-bit dividend / N-bit divisor gives
// an N-bit quotient and an N-bit remainder, one quotient bit per clock. The
// trial subtract uses the add/sub form (operand inverted, carry-in of 1).
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        request a divide; accepted only while ready=1
//   dvnd, dvsr   operands, sampled on the accepting edge only
//   ready        high in IDLE
//   done_tick    one-cycle pulse when quo/rmd/div_by_zero are newly updated
//   quo, rmd     registered quotient/remainder, held until next completion
//   div_by_zero  registered; set with a completion whose divisor was 0
module restoring_divider_nbit #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] dvnd,
  input  logic [N-1:0] dvsr,
  output logic         ready,
  output logic         done_tick,
  output logic [N-1:0] quo,
  output logic [N-1:0] rmd,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    OP,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N:0]    rh_q, rh_d;
  logic [N-1:0]  rl_q, rl_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rmd_q, rmd_d;
  logic          dbz_q, dbz_d;

  // Datapath for one iteration: shift {rh, rl} left, then trial subtract.
  // The partial remainder is always < d, so the shifted value fits in N+1
  // bits and the sign of the N+1-bit difference is a valid compare result.
  logic [N:0]   rh_shifted;
  logic [N:0]   diff;
  logic [N:0]   rh_next;
  logic [N-1:0] rl_next;

  always_comb begin
    rh_shifted = {rh_q[N-1:0], rl_q[N-1]};
    diff       = rh_shifted + ~{1'b0, d_q} + {{N{1'b0}}, 1'b1};
    rh_next    = diff[N] ? rh_shifted : diff;
    rl_next    = {rl_q[N-2:0], ~diff[N]};
  end

  always_comb begin
    state_d = state_q;
    rh_d    = rh_q;
    rl_d    = rl_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          rh_d  = '0;
          rl_d  = dvnd;
          d_d   = dvsr;
          cnt_d = CW'(N);
          if (dvsr == '0) begin
            quo_d   = '1;
            rmd_d   = dvnd;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = OP;
          end
        end
      end
      OP: begin
        rh_d  = rh_next;
        rl_d  = rl_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = rl_next;
          rmd_d   = rh_next[N-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rh_q    <= '0;
      rl_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rh_q    <= rh_d;
      rl_q    <= rl_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign done_tick   = (state_q == DONE);
  assign quo         = quo_q;
  assign rmd         = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/restoring_divider_nbit.md
# restoring_divider_nbit

Sequential unsigned restoring divider producing an N-bit quotient and an N-bit remainder from an N-bit dividend and an N-bit divisor. Each step is one shift followed by a trial subtract. The trial subtract is done in the same add/sub form used by the rest of the arithmetic library: subtract mode, with the operand inverted and a carry-in of 1. The block sits beside the combinational adder/subtractor and multiplier blocks and gives the datapath an iterative divide with a start/ready/done handshake.

## Interface
- N, default 4: operand width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset; the block is reset while reset_n is low.
- start  in  1  request a divide; accepted only when ready=1.
- dvnd  in  N  dividend (unsigned); sampled on the accepting edge only.
- dvsr  in  N  divisor (unsigned); sampled on the accepting edge only.
- ready  out  1  high in IDLE; the block can accept start.
- done_tick  out  1  one-cycle pulse; quo, rmd and div_by_zero are valid and newly updated.
- quo  out  N  quotient, registered; held until the next completion.
- rmd  out  N  remainder, registered; held until the next completion.
- div_by_zero  out  1  registered; set with a completion whose dvsr was 0.

## Operation
- FSM states: IDLE, OP, DONE.
  - IDLE: ready=1. On start=1, load the internal registers: rh (N+1 bits) = 0, rl = dvnd, d = dvsr, cnt = N.
    - If dvsr != 0: go to OP.
    - If dvsr == 0: go to DONE, with quo = all ones, rmd = dvnd, div_by_zero = 1.
  - OP: one iteration per cycle.
    - Shift {rh, rl} left by one.
    - Compute diff = rh_shifted + ~{1'b0, d} + 1, at N+1 bits.
    - If diff is non-negative (MSB = 0), rh = diff[N:0] and the new rl LSB = 1. Otherwise rh = rh_shifted and the new rl LSB = 0.
    - Decrement cnt. On the iteration where cnt = 1, register quo = new rl, rmd = new rh[N-1:0], div_by_zero = 0, and go to DONE.
  - DONE: done_tick=1 and ready=0; go to IDLE unconditionally on the next edge.
- start is ignored in OP and DONE. Requests are not queued.
- dvnd and dvsr may change freely after the accepting edge without affecting the running operation.
- Results always satisfy dvnd = quo*dvsr + rmd with rmd < dvsr, except when div_by_zero=1.
- Only unsigned arithmetic is supported. There are no overflow cases other than divide by zero.

## Timing
- Reset (asynchronous, effective immediately):
  - State = IDLE.
  - ready=1, done_tick=0, quo=0, rmd=0, div_by_zero=0.
  - Internal registers are cleared.
- Normal divide latency: start is accepted at edge E0; OP runs for N edges (E1..EN); done_tick is high for the cycle after EN; ready returns high after edge EN+1.
- Total: N+1 cycles from the accepting edge to done_tick; N+2 cycles until the next start can be accepted.
- Divide-by-zero latency: done_tick is high in the cycle after E0; ready returns high after E1.
- quo, rmd and div_by_zero change only on the edge entering DONE. They are stable at all other times, including during a subsequent operation.
- Back-to-back operation: start held high continuously gives one accepted request every N+2 cycles.
- Reset asserted mid-operation (OP or DONE): the block aborts immediately and no done_tick is produced. Outputs take their reset values, so previously held results are lost.
- Reset released: the first acceptance can occur on the first rising edge at which reset_n is high.
- done_tick is never high in two consecutive cycles.

## Test plan
- Reset, then N=4 divide 13/4, start pulsed 1 cycle -> done_tick exactly 5 cycles after the accepting edge; quo=3, rmd=1, div_by_zero=0; ready low for those 5 cycles.
- Boundary values, one run each: 15/1 -> quo=15, rmd=0. 3/7 -> quo=0, rmd=3. 15/15 -> quo=1, rmd=0. 0/5 -> quo=0, rmd=0.
- Divide by zero, 9/0 -> done_tick 1 cycle after acceptance; quo=4'hF, rmd=9, div_by_zero=1. A following 8/2 -> quo=4, rmd=0, div_by_zero=0.
- Ignored start: start 12/5 accepted; at cycle 2 pulse start with 1/1 and change dvnd/dvsr -> exactly one done_tick; quo=2, rmd=2; the second request is ignored.
- Reset mid-op: start 14/3; drop reset_n during the 3rd OP cycle -> outputs become 0 asynchronously, ready=1, no done_tick. A later 14/3 -> quo=4, rmd=2.
- Exhaustive check at N=4: all 256 operand pairs with start held high -> accept period is 6 cycles for nonzero dvsr; every result matches the reference model and div_by_zero behaviour.
